// File: rtl/ts_access_arbiter.sv
// Time-surface memory port arbiter: queued event writes, classifier reads and a
// full-surface clear sweep share one single-port RAM (1-cycle read latency).
module ts_access_arbiter #(
  parameter int ADDR_BITS       = 8,
  parameter int TS_BITS         = 16,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_READ_STREAK = 4,
  localparam int LVL_W          = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   event_valid,
  input  logic [ADDR_BITS/2-1:0] event_x,
  input  logic [ADDR_BITS/2-1:0] event_y,
  input  logic [TS_BITS-1:0]     event_ts,
  output logic                   event_ready,
  input  logic                   rd_req,
  input  logic [ADDR_BITS-1:0]   rd_addr,
  output logic                   rd_grant,
  output logic                   rd_data_valid,
  output logic [TS_BITS-1:0]     rd_data,
  input  logic                   clr_start,
  output logic                   clr_busy,
  output logic                   clr_done,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [ADDR_BITS-1:0]   mem_addr,
  output logic [TS_BITS-1:0]     mem_wdata,
  input  logic [TS_BITS-1:0]     mem_rdata,
  output logic [LVL_W-1:0]       fifo_level
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int STK_W = $clog2(MAX_READ_STREAK + 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_READ_STREAK);

  typedef enum logic [0:0] {ST_RUN, ST_CLEAR} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_BITS-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [TS_BITS-1:0]   r_fifo_ts   [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [LVL_W-1:0]     r_level;
  logic [STK_W-1:0]     r_streak;
  logic [ADDR_BITS:0]   r_clr_addr;
  logic                 r_clr_done;
  logic                 r_rd_vld_p1;
  logic                 r_rd_vld_p2;
  logic [TS_BITS-1:0]   r_rd_data_p2;

  logic                 w_fifo_empty;
  logic                 w_fifo_full;
  logic                 w_ready;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_rd_gnt;
  logic                 w_wr_gnt;
  logic                 w_clr_wr;
  logic                 w_clr_last;
  logic [ADDR_BITS:0]   w_clr_addr_inc;

  assign w_fifo_empty   = (r_level == '0);
  assign w_fifo_full    = (r_level == LVL_FULL);
  assign w_ready        = (r_level < LVL_FULL);
  assign w_push         = event_valid && w_ready;
  assign w_pop          = w_wr_gnt;
  assign w_clr_addr_inc = r_clr_addr + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Arbitration: full FIFO forces a write, reads win otherwise until the streak cap.
  always_comb begin
    w_state_nxt = r_state;
    w_rd_gnt    = 1'b0;
    w_wr_gnt    = 1'b0;
    w_clr_wr    = 1'b0;
    w_clr_last  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_fifo_full) begin
          w_wr_gnt = 1'b1;
        end else if (rd_req && (w_fifo_empty || (r_streak < STK_MAX))) begin
          w_rd_gnt = 1'b1;
        end else if (!w_fifo_empty) begin
          w_wr_gnt = 1'b1;
        end
        if (clr_start) begin
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        w_clr_wr = 1'b1;
        if (w_clr_addr_inc[ADDR_BITS]) begin
          w_clr_last  = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_clr_wr) begin
      mem_addr = r_clr_addr[ADDR_BITS-1:0];
    end else if (w_rd_gnt) begin
      mem_addr = rd_addr;
    end else if (w_wr_gnt) begin
      mem_addr  = r_fifo_addr[r_rd_ptr];
      mem_wdata = r_fifo_ts[r_rd_ptr];
    end
  end

  assign mem_en = w_rd_gnt || w_wr_gnt || w_clr_wr;
  assign mem_we = w_wr_gnt || w_clr_wr;

  // Event FIFO: storage is not reset, only pointers and level.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= {event_y, event_x};
      r_fifo_ts[r_wr_ptr]   <= event_ts;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_streak <= '0;
    end else if (w_fifo_empty || w_wr_gnt) begin
      r_streak <= '0;
    end else if (w_rd_gnt && (r_streak < STK_MAX)) begin
      r_streak <= r_streak + 1'b1;
    end
  end

  // The extra MSB marks sweep completion so the counter never wraps into a second pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clr_addr <= '0;
      r_clr_done <= 1'b0;
    end else begin
      r_clr_done <= w_clr_last;
      if (r_state == ST_CLEAR) begin
        r_clr_addr <= w_clr_addr_inc;
      end else begin
        r_clr_addr <= '0;
      end
    end
  end

  // p1: RAM access in flight; p2: RAM data captured for the classifier.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_vld_p1  <= 1'b0;
      r_rd_vld_p2  <= 1'b0;
      r_rd_data_p2 <= '0;
    end else begin
      r_rd_vld_p1 <= w_rd_gnt;
      r_rd_vld_p2 <= r_rd_vld_p1;
      if (r_rd_vld_p1) begin
        r_rd_data_p2 <= mem_rdata;
      end
    end
  end

  assign event_ready   = w_ready;
  assign rd_grant      = w_rd_gnt;
  assign rd_data_valid = r_rd_vld_p2;
  assign rd_data       = r_rd_data_p2;
  assign clr_busy      = (r_state == ST_CLEAR);
  assign clr_done      = r_clr_done;
  assign fifo_level    = r_level;

endmodule

// File: tb/tb_ts_access_arbiter.sv
// Directed bench for ts_access_arbiter with a behavioural 256x16 RAM on the memory port.
module tb_ts_access_arbiter;

  logic        clk;
  logic        rst;
  logic        event_valid;
  logic [3:0]  event_x;
  logic [3:0]  event_y;
  logic [15:0] event_ts;
  logic        event_ready;
  logic        rd_req;
  logic [7:0]  rd_addr;
  logic        rd_grant;
  logic        rd_data_valid;
  logic [15:0] rd_data;
  logic        clr_start;
  logic        clr_busy;
  logic        clr_done;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [2:0]  fifo_level;

  int tests = 0;
  int fails = 0;

  ts_access_arbiter dut (
    .clk(clk), .rst(rst),
    .event_valid(event_valid), .event_x(event_x), .event_y(event_y),
    .event_ts(event_ts), .event_ready(event_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] ram [256];
  initial begin
    for (int a = 0; a < 256; a++) ram[a] = 16'hA000 | 16'(a);
    mem_rdata = 16'h0;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    logic [7:0]  t3_addr [3];
    logic [7:0]  t4_addr [6];
    logic        exp_w;
    int          wi;
    int          ei;
    int          full_cnt;
    int          viol;

    t3_addr = '{8'h11, 8'h22, 8'h33};
    t4_addr = '{8'h40, 8'h51, 8'h62, 8'h73, 8'h84, 8'h95};

    rst = 1'b1; event_valid = 1'b0; event_x = '0; event_y = '0; event_ts = '0;
    rd_req = 1'b0; rd_addr = '0; clr_start = 1'b0;
    #1;
    repeat (3) cyc();
    #1;
    chk("rst_ready", event_ready, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_outs", {mem_en, mem_we, rd_grant, rd_data_valid, clr_busy, clr_done}, 0);
    chk("rst_bus", {mem_addr, mem_wdata}, 0);
    chk("rst_rdata", rd_data, 0);
    rst = 1'b0;
    cyc();

    // single event write
    event_valid = 1'b1; event_x = 4'd3; event_y = 4'd5; event_ts = 16'h1234;
    #1;
    chk("t1_ready", event_ready, 1);
    chk("t1_idle", mem_en, 0);
    cyc();
    event_valid = 1'b0;
    #1;
    chk("t1_level1", fifo_level, 1);
    chk("t1_en_we", {mem_en, mem_we}, 2'b11);
    chk("t1_addr", mem_addr, 8'h53);
    chk("t1_wdata", mem_wdata, 16'h1234);
    cyc();
    #1;
    chk("t1_level0", fifo_level, 0);
    chk("t1_quiet", mem_en, 0);

    // single read, 2-cycle data latency
    rd_req = 1'b1; rd_addr = 8'h53;
    #1;
    chk("t2_grant", rd_grant, 1);
    chk("t2_en_we", {mem_en, mem_we}, 2'b10);
    chk("t2_addr", mem_addr, 8'h53);
    cyc();
    rd_req = 1'b0;
    #1;
    chk("t2_vld_early", rd_data_valid, 0);
    cyc();
    #1;
    chk("t2_vld", rd_data_valid, 1);
    chk("t2_data", rd_data, 16'h1234);
    cyc();
    #1;
    chk("t2_vld_off", rd_data_valid, 0);
    chk("t2_hold", rd_data, 16'h1234);

    // held reads with 3 events: streak cap forces a write every fifth grant
    rd_req = 1'b1; rd_addr = 8'h10; wi = 0;
    for (int k = 0; k < 16; k++) begin
      event_valid = (k < 3);
      event_x = 4'(k + 1); event_y = 4'(k + 1); event_ts = 16'h00A1 + 16'(k);
      #1;
      exp_w = (k == 5 || k == 10 || k == 15);
      chk("t3_rd", rd_grant, !exp_w);
      chk("t3_wr", mem_en && mem_we, exp_w);
      if (mem_en && mem_we && wi < 3) begin
        chk("t3_waddr", mem_addr, t3_addr[wi]);
        chk("t3_wdata", mem_wdata, 16'h00A1 + 16'(wi));
        wi++;
      end
      cyc();
    end
    event_valid = 1'b0; rd_req = 1'b0;
    #1;
    chk("t3_writes", wi, 3);
    chk("t3_level", fifo_level, 0);
    repeat (3) cyc();

    // 6 back-to-back events under read pressure: back-pressure and forced writes
    rd_req = 1'b1; wi = 0; ei = 0; full_cnt = 0;
    for (int k = 0; k < 60 && wi < 6; k++) begin
      event_valid = (ei < 6);
      event_x = 4'(ei); event_y = 4'(ei + 4); event_ts = 16'h0100 + 16'(ei);
      #1;
      chk("t4_lvl_max", fifo_level <= 3'd4, 1);
      chk("t4_ready", event_ready, fifo_level != 3'd4);
      if (fifo_level == 3'd4) begin
        full_cnt++;
        chk("t4_force", {mem_en, mem_we, rd_grant}, 3'b110);
      end
      if (mem_en && mem_we) begin
        if (wi < 6) begin
          chk("t4_waddr", mem_addr, t4_addr[wi]);
          chk("t4_wdata", mem_wdata, 16'h0100 + 16'(wi));
        end
        wi++;
      end
      if (event_valid && event_ready) ei++;
      cyc();
    end
    event_valid = 1'b0; rd_req = 1'b0;
    #1;
    chk("t4_written", wi, 6);
    chk("t4_accepted", ei, 6);
    chk("t4_full_cycles", full_cnt, 3);
    chk("t4_level", fifo_level, 0);
    viol = 0;
    for (int k = 0; k < 3; k++) begin
      if (mem_en) viol++;
      cyc();
    end
    chk("t4_no_dup", viol, 0);

    // clear sweep with reads, a repeated clr_start and an event during the sweep
    clr_start = 1'b1;
    #1;
    chk("t5_not_busy_yet", clr_busy, 0);
    cyc();
    clr_start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      rd_req      = (i >= 10 && i < 20);
      rd_addr     = 8'h53;
      clr_start   = (i == 50);
      event_valid = (i == 100);
      event_x = 4'd1; event_y = 4'd2; event_ts = 16'h7777;
      #1;
      chk("t5_sweep", {clr_busy, mem_en, mem_we, rd_grant, clr_done, mem_addr, mem_wdata},
          {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'(i), 16'h0000});
      if (i == 100) chk("t5_ev_ready", event_ready, 1);
      if (i == 101) chk("t5_ev_queued", fifo_level, 1);
      cyc();
    end
    rd_req = 1'b0; clr_start = 1'b0; event_valid = 1'b0;
    #1;
    chk("t5_busy_off", clr_busy, 0);
    chk("t5_done", clr_done, 1);
    chk("t5_ev_write", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 8'h21, 16'h7777});
    cyc();
    #1;
    chk("t5_done_pulse", clr_done, 0);
    chk("t5_quiet", {mem_en, clr_busy}, 0);
    chk("t5_level", fifo_level, 0);
    rd_req = 1'b1; rd_addr = 8'h53;
    cyc();
    rd_req = 1'b0;
    cyc();
    #1;
    chk("t5_cleared_vld", rd_data_valid, 1);
    chk("t5_cleared_data", rd_data, 16'h0000);
    cyc();

    // reset in the middle of a sweep
    clr_start = 1'b1;
    cyc();
    clr_start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      event_valid = (i == 5);
      event_x = 4'd7; event_y = 4'd7; event_ts = 16'h5555;
      cyc();
    end
    event_valid = 1'b0;
    #1;
    chk("t6_at_100", {clr_busy, mem_addr}, {1'b1, 8'd100});
    chk("t6_queued", fifo_level, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("t6_busy", clr_busy, 0);
    chk("t6_level", fifo_level, 0);
    chk("t6_ready", event_ready, 1);
    chk("t6_no_done", clr_done, 0);
    chk("t6_no_mem", mem_en, 0);
    viol = 0;
    for (int k = 0; k < 300; k++) begin
      if (mem_en || clr_done || clr_busy) viol++;
      cyc();
    end
    chk("t6_stays_quiet", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ts_access_arbiter.md
Name: ts_access_arbiter

Overview:
- Arbitrates the single time-surface memory port (256 x 16-bit, 1-cycle read latency) between three requesters: event timestamp writes, classifier scan reads, and a full-surface clear sweep.
- Sits between the pre-decoded event bus / spatio-temporal classifier and the surface RAM.
- Gives the event input real back-pressure via a small FIFO, so event_ready is no longer tied high.

Parameters:
- ADDR_BITS, 8, memory address width (16x16 grid).
- TS_BITS, 16, timestamp / memory data width.
- FIFO_DEPTH, 4, event FIFO entries (power of 2).
- MAX_READ_STREAK, 4, max consecutive read grants while the FIFO is non-empty.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- event_valid  in  1  event present
- event_x  in  4  grid x
- event_y  in  4  grid y
- event_ts  in  TS_BITS  event timestamp
- event_ready  out  1  FIFO can accept
- rd_req  in  1  classifier read request (held until granted)
- rd_addr  in  ADDR_BITS  read address
- rd_grant  out  1  read issued this cycle
- rd_data_valid  out  1  read data valid pulse
- rd_data  out  TS_BITS  read data
- clr_start  in  1  start-clear pulse
- clr_busy  out  1  clear sweep in progress
- clr_done  out  1  one-cycle completion pulse
- mem_en  out  1  memory access enable
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_BITS  memory address
- mem_wdata  out  TS_BITS  write data
- mem_rdata  in  TS_BITS  read data, valid the cycle after the access
- fifo_level  out  3  FIFO occupancy 0..FIFO_DEPTH

Behaviour:
- Reset: FIFO empty, state RUN, streak 0, clear address 0. All outputs 0 except event_ready = 1.
- event_ready is combinational: (registered level < FIFO_DEPTH).
  - No push is accepted when full, even if a pop occurs in the same cycle.
  - A push in cycle N can pop no earlier than N+1.
- Write entry: addr = {event_y, event_x}, data = event_ts. Entries are written in FIFO order.
- State RUN, one memory operation per cycle, priority in this order:
  1. FIFO full: write.
  2. rd_req and (FIFO empty or streak < MAX_READ_STREAK): read.
  3. FIFO non-empty: write.
  4. Otherwise idle, mem_en = 0.
- rd_grant is combinational and equals the read decision; mem_addr = rd_addr in that cycle.
- Read completion: rd_data_valid and rd_data are registered and appear exactly 2 cycles after the grant cycle.
  - rd_data holds its value between pulses.
  - An in-flight read always completes, including across a clr_start.
- Streak counter:
  - Increments on each read grant while the FIFO is non-empty, saturating at MAX_READ_STREAK.
  - Clears on any write grant or whenever the FIFO is empty.
- Hazard: a read of an address whose write is still queued returns the old memory value. This is intended; no forwarding is performed.
- clr_start in RUN: the current cycle arbitrates normally; the block enters CLEAR on the next cycle. clr_start while in CLEAR is ignored.
- State CLEAR:
  - Writes 0 to addresses 0..2^ADDR_BITS-1, one per cycle, ascending (256 cycles at defaults).
  - clr_busy = 1 throughout; rd_grant = 0; the FIFO keeps accepting events until full but does not pop.
  - After the last write, clr_done pulses for 1 cycle and the block returns to RUN.
  - Queued events are written after the clear, so events arriving during a clear survive.
- Reset mid-clear: the sweep is abandoned, clr_busy = 0, no clr_done pulse, FIFO emptied.
- Address wrap: the clear counter is ADDR_BITS+1 wide; the block terminates on the MSB and never re-sweeps.

Test Plan:
- Idle, one event x=3, y=5, ts=0x1234 at cycle N -> at N+1: mem_en=1, mem_we=1, mem_addr=0x53, mem_wdata=0x1234; fifo_level returns to 0.
- FIFO empty, rd_req with addr 0x53 -> rd_grant same cycle, mem_we=0; rd_data_valid at +2 cycles with rd_data = memory content (0x1234 after test 1).
- rd_req held continuously, 3 events pushed -> grant pattern of 4 reads then 1 write, repeating; all 3 writes complete within 15 cycles, in order.
- rd_req held, 6 events offered back-to-back -> event_ready drops at level 4; fifo_level never exceeds 4; each full cycle forces a write; all 6 written, none lost or duplicated.
- clr_start -> 256 consecutive writes, addr 0x00..0xFF, data 0; clr_busy high for 256 cycles; clr_done pulses once; rd_req during clear gets no grant; an event (x=1, y=2) arriving mid-clear is written to 0x21 after clr_done.
- rst asserted while clearing address 100 -> next cycle: clr_busy=0, fifo_level=0, event_ready=1; no clr_done; no further memory accesses until new requests arrive.
